// File: rtl/exe_stage.sv
// Execute stage: operand muxing, ALU/shifter, zero flag and the EXE/MEM pipeline register.
// The ALU result is also exposed combinationally for ID-stage forwarding.
module exe_stage #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RNW = 5
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           stall,
    input  logic           flush,
    input  logic           exe_wreg,
    input  logic           exe_m2reg,
    input  logic           exe_wmem,
    input  logic [2:0]     exe_aluc,
    input  logic           exe_aluimm,
    input  logic           exe_shift,
    input  logic           exe_wz,
    input  logic [DW-1:0]  exe_a,
    input  logic [DW-1:0]  exe_b,
    input  logic [DW-1:0]  exe_imm,
    input  logic [RNW-1:0] exe_rn,
    output logic [DW-1:0]  exe_alu,
    output logic           exe_fwd_wr,
    output logic           exe_fwd_ld,
    output logic           z_flag,
    output logic           mem_wreg,
    output logic           mem_m2reg,
    output logic           mem_wmem,
    output logic [DW-1:0]  mem_alu,
    output logic [DW-1:0]  mem_b,
    output logic [RNW-1:0] mem_rn
);

    logic [DW-1:0]  op_a, op_b;
    logic [4:0]     sa;

    logic           z_q, z_d;
    logic           wreg_q, wreg_d;
    logic           m2reg_q, m2reg_d;
    logic           wmem_q, wmem_d;
    logic [DW-1:0]  alu_q, alu_d;
    logic [DW-1:0]  b_q, b_d;
    logic [RNW-1:0] rn_q, rn_d;

    // Shift-immediate instructions take the shift amount from the shamt field.
    assign op_a = exe_shift ? {{(DW-5){1'b0}}, exe_imm[10:6]} : exe_a;
    assign op_b = exe_aluimm ? exe_imm : exe_b;
    assign sa   = op_a[4:0];

    always_comb begin
        exe_alu = '0;
        unique case (exe_aluc)
            3'b000:  exe_alu = op_a + op_b;
            3'b001:  exe_alu = op_a - op_b;
            3'b010:  exe_alu = op_a & op_b;
            3'b011:  exe_alu = op_a | op_b;
            3'b100:  exe_alu = op_a ^ op_b;
            3'b101:  exe_alu = op_b << sa;
            3'b110:  exe_alu = op_b >> sa;
            3'b111:  exe_alu = $unsigned($signed(op_b) >>> sa);
            default: exe_alu = '0;
        endcase
    end

    assign exe_fwd_wr = exe_wreg;
    assign exe_fwd_ld = exe_wreg & exe_m2reg;

    always_comb begin
        z_d     = z_q;
        wreg_d  = wreg_q;
        m2reg_d = m2reg_q;
        wmem_d  = wmem_q;
        alu_d   = alu_q;
        b_d     = b_q;
        rn_d    = rn_q;
        if (flush) begin
            // Bubble: Z is left alone so a pending branch still sees it.
            wreg_d  = 1'b0;
            m2reg_d = 1'b0;
            wmem_d  = 1'b0;
            alu_d   = '0;
            b_d     = '0;
            rn_d    = '0;
        end else if (!stall) begin
            wreg_d  = exe_wreg;
            m2reg_d = exe_m2reg;
            wmem_d  = exe_wmem;
            alu_d   = exe_alu;
            b_d     = exe_b;
            rn_d    = exe_rn;
            if (exe_wz) begin
                z_d = (exe_alu == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            z_q     <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            alu_q   <= '0;
            b_q     <= '0;
            rn_q    <= '0;
        end else begin
            z_q     <= z_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wmem_q  <= wmem_d;
            alu_q   <= alu_d;
            b_q     <= b_d;
            rn_q    <= rn_d;
        end
    end

    assign z_flag    = z_q;
    assign mem_wreg  = wreg_q;
    assign mem_m2reg = m2reg_q;
    assign mem_wmem  = wmem_q;
    assign mem_alu   = alu_q;
    assign mem_b     = b_q;
    assign mem_rn    = rn_q;

endmodule
